// File: rtl/ps2_keyboard_decoder.sv
// PS/2 scan-code set 2 decoder: turns receiver bytes into make/break events queued in a FIFO.
// Define PS2_KBD_MODIFIER_TRACK_EN to report live shift/ctrl state in ev_data[11:10].
module ps2_keyboard_decoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned TIMEOUT    = 1048576
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_toggle,
    output logic [11:0] ev_data,
    output logic        ev_valid,
    input  logic        ev_pop,
    output logic [5:0]  ev_count,
    output logic        overflow,
    input  logic        clear_ovf
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, E0, F0, E0F0, SKIP} state_t;

    state_t          state, state_next;
    logic            tog_q;
    logic            byte_valid;
    logic [2:0]      skip_cnt, skip_next;
    logic [TW-1:0]   tmo_cnt, tmo_next;
    logic            emit, emit_ext, emit_rel;
    logic [7:0]      emit_code;
    logic [1:0]      mod_bits;
    logic [11:0]     ev_word;

    assign byte_valid = (rx_toggle != tog_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tog_q    <= rx_toggle;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_next;
            tog_q    <= rx_toggle;
            skip_cnt <= skip_next;
            tmo_cnt  <= tmo_next;
        end
    end

    always_comb begin
        state_next = state;
        skip_next  = skip_cnt;
        tmo_next   = tmo_cnt;
        emit       = 1'b0;
        emit_code  = rx_data;
        emit_ext   = 1'b0;
        emit_rel   = 1'b0;
        if (byte_valid) begin
            tmo_next = '0;
            unique case (state)
                IDLE: begin
                    case (rx_data)
                        8'hE0: state_next = E0;
                        8'hF0: state_next = F0;
                        8'hE1: begin
                            state_next = SKIP;
                            skip_next  = 3'd7;
                        end
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: ;
                        default: emit = 1'b1;
                    endcase
                end
                E0: begin
                    if (rx_data == 8'hF0) begin
                        state_next = E0F0;
                    end else begin
                        state_next = IDLE;
                        emit       = (rx_data != 8'h12);
                        emit_ext   = 1'b1;
                    end
                end
                F0: begin
                    state_next = IDLE;
                    emit       = 1'b1;
                    emit_rel   = 1'b1;
                end
                E0F0: begin
                    state_next = IDLE;
                    emit       = (rx_data != 8'h12);
                    emit_ext   = 1'b1;
                    emit_rel   = 1'b1;
                end
                SKIP: begin
                    skip_next = skip_cnt - 3'd1;
                    if (skip_cnt <= 3'd1) begin
                        state_next = IDLE;
                        skip_next  = '0;
                        emit       = 1'b1;
                        emit_code  = 8'hE1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE) begin
            // abandon a stalled prefix so a lost byte cannot corrupt the next key
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                state_next = IDLE;
                skip_next  = '0;
                tmo_next   = '0;
            end else begin
                tmo_next = tmo_cnt + TW'(1);
            end
        end
    end

`ifdef PS2_KBD_MODIFIER_TRACK_EN
    logic [3:0] mods, mods_next;  // {rctrl, lctrl, rshift, lshift}

    always_comb begin
        mods_next = mods;
        if (emit && !emit_ext) begin
            case (emit_code)
                8'h12:   mods_next[0] = !emit_rel;
                8'h59:   mods_next[1] = !emit_rel;
                8'h14:   mods_next[2] = !emit_rel;
                default: ;
            endcase
        end else if (emit && emit_ext && emit_code == 8'h14) begin
            mods_next[3] = !emit_rel;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) mods <= '0;
        else       mods <= mods_next;
    end

    assign mod_bits = {mods_next[3] | mods_next[2], mods_next[1] | mods_next[0]};
`else
    assign mod_bits = 2'b00;
`endif

    assign ev_word = {mod_bits, emit_rel, emit_ext, emit_code};

    logic [11:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [5:0]    count;
    logic [11:0]   last_head;
    logic          full, do_pop, do_push, drop;

    assign full    = (count == 6'(FIFO_DEPTH));
    assign do_pop  = ev_pop && (count != '0);
    assign do_push = emit && (!full || do_pop);
    assign drop    = emit && full && !do_pop;

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= ev_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            last_head <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                last_head <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 6'd1;
                2'b01:   count <= count - 6'd1;
                default: ;
            endcase
            if (clear_ovf) overflow <= drop;
            else if (drop) overflow <= 1'b1;
        end
    end

    assign ev_valid = (count != '0);
    assign ev_count = count;
    assign ev_data  = ev_valid ? mem[rd_ptr] : last_head;
endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Self-checking bench for ps2_keyboard_decoder: fixed vectors, corner sequences and a
// randomized run against a byte-sequence reference model.
module tb_ps2_keyboard_decoder;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned TMO   = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_toggle = 1'b0;
    logic [11:0] ev_data;
    logic        ev_valid;
    logic        ev_pop = 1'b0;
    logic [5:0]  ev_count;
    logic        overflow;
    logic        clear_ovf = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    ps2_keyboard_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_toggle(rx_toggle),
        .ev_data(ev_data), .ev_valid(ev_valid), .ev_pop(ev_pop), .ev_count(ev_count),
        .overflow(overflow), .clear_ovf(clear_ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, assertions=%0d failures=%0d", n_assert, n_fail);
        $fatal(1);
    end

    // Reference model: pending prefix bytes, event queue, held modifier keys.
    logic [7:0]  pend[$];
    logic [11:0] q[$];
    bit          ovf;
    bit          have_last;
    logic [11:0] last;
    int          idle_cnt;
    bit          held[512];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_clear();
        pend.delete();
        q.delete();
        ovf = 0;
        have_last = 0;
        idle_cnt = 0;
        foreach (held[k]) held[k] = 0;
    endfunction

    function automatic void decode(input logic [7:0] b, output bit e, output logic [11:0] w);
        bit ext, rel, shift, ctrl;
        logic [7:0] code;
        int key;
        e = 0; ext = 0; rel = 0; code = b; w = '0; shift = 0; ctrl = 0;
        if (pend.size() == 0) begin
            if (b == 8'hE0 || b == 8'hF0 || b == 8'hE1) pend.push_back(b);
            else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) e = 1;
        end else if (pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) begin
                e = 1; code = 8'hE1; pend.delete();
            end
        end else if (pend[0] == 8'hF0) begin
            e = 1; rel = 1; pend.delete();
        end else if (pend.size() == 1) begin
            if (b == 8'hF0) pend.push_back(b);
            else begin
                pend.delete(); e = (b != 8'h12); ext = 1;
            end
        end else begin
            pend.delete(); e = (b != 8'h12); ext = 1; rel = 1;
        end
        if (e) begin
            key = ext * 256 + int'(code);
`ifdef PS2_KBD_MODIFIER_TRACK_EN
            if (key == 'h012 || key == 'h059 || key == 'h014 || key == 'h114) held[key] = !rel;
            shift = held['h012] | held['h059];
            ctrl  = held['h014] | held['h114];
`endif
            w = {ctrl, shift, rel, ext, code};
        end
    endfunction

    function automatic void model_edge(input bit send, input logic [7:0] b, input bit pop, input bit clr);
        bit e, drop;
        logic [11:0] w;
        e = 0; w = '0;
        if (send) begin
            if (idle_cnt >= int'(TMO)) pend.delete();
            idle_cnt = 0;
            decode(b, e, w);
        end else begin
            idle_cnt++;
        end
        if (pop && q.size() > 0) begin
            last = q.pop_front();
            have_last = 1;
        end
        drop = e && (q.size() >= int'(DEPTH));
        if (e && !drop) q.push_back(w);
        ovf = clr ? drop : (ovf | drop);
    endfunction

    task automatic check_outputs();
        chk("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
        chk("ev_count", 32'(ev_count), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(ovf));
        if (q.size() != 0)  chk("ev_data head", 32'(ev_data), 32'(q[0]));
        else if (have_last) chk("ev_data stale", 32'(ev_data), 32'(last));
    endtask

    task automatic step(input bit send, input logic [7:0] b, input bit pop, input bit clr);
        @(negedge clock);
        if (send) begin
            rx_data   = b;
            rx_toggle = ~rx_toggle;
        end
        ev_pop    = pop;
        clear_ovf = clr;
        @(posedge clock);
        #1;
        ev_pop    = 1'b0;
        clear_ovf = 1'b0;
        model_edge(send, b, pop, clr);
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        rx_toggle = ~rx_toggle;  // toggle during reset must not become a byte
        ev_pop    = 1'b0;
        clear_ovf = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        chk("reset ev_valid", 32'(ev_valid), 32'd0);
        chk("reset ev_count", 32'(ev_count), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 11))
            0:  return 8'h12;
            1:  return 8'h59;
            2:  return 8'h14;
            3:  return 8'hE0;
            4:  return 8'hF0;
            5:  return 8'hE1;
            6:  return 8'hAA;
            7:  return 8'h00;
            8:  return 8'h1C;
            9:  return 8'h75;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    typedef struct packed {
        logic [3:0]  n;
        logic [63:0] bytes;  // first byte in the top octet
        logic [2:0]  nexp;
        logic [47:0] exp;    // first event in the top 12 bits
    } vec_t;

    function automatic vec_t mk(input int n, input logic [63:0] b, input int ne, input logic [47:0] e);
        vec_t v;
        v.n = 4'(n); v.bytes = b; v.nexp = 3'(ne); v.exp = e;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        vec_t v;
        logic [7:0]  b;
        logic [11:0] e;

        vecs[0] = mk(3, 64'h1CF01C0000000000, 2, 48'h01C21C000000);
        vecs[1] = mk(7, 64'hE075E0F075E01200, 2, 48'h175375000000);
        vecs[2] = mk(8, 64'hE11477E1F014F077, 1, 48'h0E1000000000);
`ifdef PS2_KBD_MODIFIER_TRACK_EN
        vecs[3] = mk(5, 64'h121CF0121C000000, 4, 48'h41241C21201C);
        vecs[5] = mk(8, 64'h59E014E0F014F059, 4, 48'h459D14714259);
`else
        vecs[3] = mk(5, 64'h121CF0121C000000, 4, 48'h01201C21201C);
        vecs[5] = mk(8, 64'h59E014E0F014F059, 4, 48'h059114314259);
`endif
        vecs[4] = mk(6, 64'hAAFA00E0F0120000, 0, 48'h0);

        do_reset();
        step(0, 8'h00, 0, 0);

        for (int vi = 0; vi < 6; vi++) begin
            v = vecs[vi];
            do_reset();
            for (int i = 0; i < int'(v.n); i++) begin
                b = v.bytes[63 - 8 * i -: 8];
                step(1, b, 0, 0);
            end
            chk($sformatf("vec%0d count", vi), 32'(ev_count), 32'(v.nexp));
            for (int j = 0; j < int'(v.nexp); j++) begin
                e = v.exp[47 - 12 * j -: 12];
                chk($sformatf("vec%0d event%0d", vi, j), 32'(ev_data), 32'(e));
                step(0, 8'h00, 1, 0);
            end
            chk($sformatf("vec%0d drained", vi), 32'(ev_valid), 32'd0);
        end

        // Timeout: 20 idle cycles abandon F0, 15 do not.
        do_reset();
        step(1, 8'hF0, 0, 0);
        repeat (20) step(0, 8'h00, 0, 0);
        step(1, 8'h1C, 0, 0);
        chk("timeout abandons F0", 32'(ev_data), 32'h01C);
        step(0, 8'h00, 1, 0);
        step(1, 8'hF0, 0, 0);
        repeat (15) step(0, 8'h00, 0, 0);
        step(1, 8'h1C, 0, 0);
        chk("below timeout keeps F0", 32'(ev_data), 32'h21C);
        step(0, 8'h00, 1, 0);

        // Overflow, clear, push-with-pop on full, clear racing a drop, empty pop.
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 8'h15 + 8'(i), 0, 0);
        chk("full count", 32'(ev_count), 32'd8);
        chk("full overflow", 32'(overflow), 32'd1);
        chk("full head", 32'(ev_data), 32'h015);
        step(0, 8'h00, 0, 1);
        chk("ovf cleared", 32'(overflow), 32'd0);
        step(1, 8'h2A, 1, 0);
        chk("push+pop full count", 32'(ev_count), 32'd8);
        chk("push+pop full ovf", 32'(overflow), 32'd0);
        chk("push+pop head", 32'(ev_data), 32'h016);
        step(1, 8'h2B, 0, 1);
        chk("clear vs drop", 32'(overflow), 32'd1);
        repeat (8) step(0, 8'h00, 1, 0);
        chk("empty stale head", 32'(ev_data), 32'h02A);
        step(0, 8'h00, 1, 0);
        chk("empty pop count", 32'(ev_count), 32'd0);

        // Reset in the middle of an E0 prefix with queued events.
        do_reset();
        step(1, 8'h1C, 0, 0);
        step(1, 8'h1D, 0, 0);
        step(1, 8'h1E, 0, 0);
        step(1, 8'hE0, 0, 0);
        chk("queued before reset", 32'(ev_count), 32'd3);
        do_reset();
        step(1, 8'h75, 0, 0);
        chk("after reset 0x75", 32'(ev_data), 32'h075);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0)
                repeat (TMO + 4) step(0, 8'h00, $urandom_range(0, 3) == 0, 0);
            else
                step($urandom_range(0, 9) < 6, rand_byte(), $urandom_range(0, 9) < 3,
                     $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_decoder.md
PS2_KEYBOARD_DECODER -- requirements
Module: ps2_keyboard_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries (power of two, 2..32).
REQ-002 SHALL have parameter TIMEOUT, default 1048576, idle clock cycles before a partial sequence is abandoned.
REQ-003 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  last byte from upstream PS/2 receiver, stable while rx_toggle is unchanged.
REQ-006 SHALL have port rx_toggle  input  1  inverts once per new valid byte on rx_data.
REQ-007 SHALL have port ev_data  output  12  FIFO head: [7:0] code, [8] extended, [9] release, [10] shift, [11] ctrl.
REQ-008 SHALL have port ev_valid  output  1  FIFO non-empty.
REQ-009 SHALL have port ev_pop  input  1  one-cycle pulse; removes head.
REQ-010 SHALL have port ev_count  output  6  current FIFO occupancy.
REQ-011 SHALL have port overflow  output  1  sticky; set when an event is dropped.
REQ-012 SHALL have port clear_ovf  input  1  pulse; clears overflow.

Function
REQ-013 SHALL register rx_toggle into tog_q; a byte is consumed in the cycle rx_toggle != tog_q, and tog_q updates that edge.
REQ-014 SHALL implement FSM states IDLE, E0, F0, E0F0, SKIP.
REQ-015 IDLE: 0xE0 -> E0; 0xF0 -> F0; 0xE1 -> SKIP with skip_cnt=7; 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF discarded, stay IDLE; other byte -> emit {ext=0, rel=0}, stay IDLE.
REQ-016 E0: 0xF0 -> E0F0; 0x12 (fake shift) discarded -> IDLE; other -> emit {ext=1, rel=0} -> IDLE.
REQ-017 F0: any byte -> emit {ext=0, rel=1} -> IDLE; E0F0: 0x12 discarded -> IDLE, else emit {ext=1, rel=1} -> IDLE.
REQ-018 SKIP: each consumed byte decrements skip_cnt; on byte with skip_cnt==1 emit {code=0xE1, ext=0, rel=0} -> IDLE.
REQ-019 SHALL count cycles without a consumed byte in any non-IDLE state; on reaching TIMEOUT, FSM -> IDLE, nothing emitted; counter clears on every consumed byte.
REQ-020 Emitted event SHALL be written to FIFO on the same edge the byte is consumed; ev_valid/ev_data reflect it from the next cycle (first-word fall-through, ev_data = head combinationally).
REQ-021 ev_pop with FIFO empty SHALL be ignored; ev_data undefined-but-stable (last head) when empty.
REQ-022 Push with FIFO full and no pop SHALL drop the event and set overflow; push with full and ev_pop same cycle SHALL be accepted (count unchanged).
REQ-023 clear_ovf and a simultaneous drop SHALL leave overflow set.
REQ-024 Pointers SHALL wrap modulo FIFO_DEPTH; ev_count SHALL never exceed FIFO_DEPTH.

Reset
REQ-025 On reset: FSM IDLE, skip_cnt 0, timeout counter 0, FIFO empty, ev_valid 0, ev_count 0, overflow 0, modifier state 0, tog_q loaded with current rx_toggle (no spurious byte after reset).
REQ-026 Reset mid-sequence SHALL discard the partial sequence and all FIFO contents.

Configuration
REQ-027 Macro PS2_KBD_MODIFIER_TRACK_EN defined: SHALL track left shift (0x12), right shift (0x59), left ctrl (0x14), right ctrl (E0 0x14) as four make/break flags; ev_data[10]=either shift, [11]=either ctrl, value after applying the current event.
REQ-028 Macro undefined: ev_data[11:10] SHALL be constant 0 and no modifier registers synthesized.

Verification
REQ-029 Bytes 0x1C; 0xF0,0x1C -> events 0x01C then 0x21C, ev_count 2.
REQ-030 Bytes 0xE0,0x75; 0xE0,0xF0,0x75 -> 0x175 then 0x375; 0xE0,0x12 -> no event.
REQ-031 Pause E1 14 77 E1 F0 14 F0 77 -> single event 0x0E1; TIMEOUT=16, byte 0xF0 then 20 idle cycles then 0x1C -> event 0x01C (not release).
REQ-032 FIFO_DEPTH=8, 9 make codes without pop -> ev_count 8, overflow 1, 9th lost; 9th push with simultaneous ev_pop -> accepted, overflow 0.
REQ-033 With PS2_KBD_MODIFIER_TRACK_EN: 0x12, 0x1C, F0 0x12, 0x1C -> 0x412, 0x41C, 0x212, 0x01C; without macro -> 0x012, 0x01C, 0x212, 0x01C.
REQ-034 Reset asserted after 0xE0 with 3 queued events -> ev_valid 0; next 0x75 -> 0x075.
